// File: rtl/stack_rpn_alu.sv
// RPN integer stack machine with valid/ready commands. Binary ops consume two
// entries and push the result; MUL runs as an N-cycle shift-add on magnitudes.
module stack_rpn_alu #(
  parameter int unsigned N        = 32,
  parameter int unsigned DEPTH    = 16,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 opcode,
  input  logic [N-1:0]               input_data,
  output logic [N-1:0]               output_data,
  output logic                       out_valid,
  output logic                       overflow,
  output logic                       stack_error,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(N);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_DUP  = 3'b010;
  localparam logic [2:0] OP_SWAP = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;
  state_t state;

  logic [N-1:0]   stack [DEPTH];
  logic [AW-1:0]  t_idx, s_idx, p_idx;
  logic [N-1:0]   t_val, s_val, t_mag, s_mag;
  logic           has1, has2, full;
  logic [N:0]     sum;
  logic           sum_ovf;
  logic [N-1:0]   sum_res;
  logic [2*N-1:0] mcand, acc, acc_next, prod;
  logic [N-1:0]   mplier;
  logic           mneg;
  logic [CW-1:0]  cnt;
  logic           mul_ovf;
  logic [N-1:0]   mul_res;

  assign in_ready = (state == IDLE);

  // Clamp to the signed extreme matching the exact result's sign.
  function automatic logic [N-1:0] clamp(input logic ovf, input logic neg,
                                         input logic [N-1:0] raw);
    if (SATURATE && ovf)
      clamp = neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    else
      clamp = raw;
  endfunction

  always_comb begin
    t_idx = AW'(depth - DW'(1));
    s_idx = AW'(depth - DW'(2));
    p_idx = AW'(depth);
    t_val = stack[t_idx];
    s_val = stack[s_idx];
    has1  = (depth != '0);
    has2  = (depth >= DW'(2));
    full  = (depth == DW'(DEPTH));
    if (opcode == OP_SUB)
      sum = {s_val[N-1], s_val} - {t_val[N-1], t_val};
    else
      sum = {s_val[N-1], s_val} + {t_val[N-1], t_val};
    sum_ovf = sum[N] ^ sum[N-1];
    sum_res = clamp(sum_ovf, sum[N], sum[N-1:0]);
    // Magnitude of -2^(N-1) is 2^(N-1), which still fits as an unsigned N-bit value.
    t_mag    = t_val[N-1] ? -t_val : t_val;
    s_mag    = s_val[N-1] ? -s_val : s_val;
    acc_next = mplier[0] ? (acc + mcand) : acc;
    prod     = mneg ? -acc_next : acc_next;
    mul_ovf  = (prod[2*N-1:N-1] != {(N+1){prod[2*N-1]}});
    mul_res  = clamp(mul_ovf, prod[2*N-1], prod[N-1:0]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      depth       <= '0;
      output_data <= '0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
      stack_error <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      mneg        <= 1'b0;
      cnt         <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && opcode != OP_NOP) begin
            stack_error <= 1'b0;
            overflow    <= 1'b0;
            case (opcode)
              OP_SUB, OP_ADD: begin
                if (has2) begin
                  stack[s_idx] <= sum_res;
                  depth        <= depth - DW'(1);
                  output_data  <= sum_res;
                  overflow     <= sum_ovf;
                  out_valid    <= 1'b1;
                end else stack_error <= 1'b1;
              end
              OP_MUL: begin
                // Overflow keeps its old value until the product completes.
                if (has2) begin
                  overflow <= overflow;
                  acc      <= '0;
                  mcand    <= {{N{1'b0}}, s_mag};
                  mplier   <= t_mag;
                  mneg     <= s_val[N-1] ^ t_val[N-1];
                  cnt      <= '0;
                  state    <= MUL;
                end else stack_error <= 1'b1;
              end
              OP_DUP: begin
                if (has1 && !full) begin
                  stack[p_idx] <= t_val;
                  depth        <= depth + DW'(1);
                end else stack_error <= 1'b1;
              end
              OP_SWAP: begin
                if (has2) begin
                  stack[t_idx] <= s_val;
                  stack[s_idx] <= t_val;
                end else stack_error <= 1'b1;
              end
              OP_PUSH: begin
                if (!full) begin
                  stack[p_idx] <= input_data;
                  depth        <= depth + DW'(1);
                end else stack_error <= 1'b1;
              end
              OP_POP: begin
                if (has1) begin
                  output_data <= t_val;
                  depth       <= depth - DW'(1);
                  out_valid   <= 1'b1;
                end else stack_error <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            stack[s_idx] <= mul_res;
            depth        <= depth - DW'(1);
            output_data  <= mul_res;
            overflow     <= mul_ovf;
            out_valid    <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stack_rpn_alu.md
# stack_rpn_alu

Parametrised successor to the single-cycle stack ALU: a true RPN stack machine whose binary operations consume their operands and push the result back. It adds SUB, DUP and SWAP, and a valid/ready command handshake. Multiplication is iterative and multi-cycle. It reports stack faults, and arithmetic overflow optionally saturates. It sits behind the command sequencer as the integer evaluation engine.

## Interface
- N, 32, data width in bits (signed two's complement), ≥ 4
- DEPTH, 16, stack entries, ≥ 2
- SATURATE, 0, 1 = clamp overflowed ADD/SUB/MUL results to the signed max/min
- clock  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  command present
- in_ready  out  1  command accepted when in_valid && in_ready at a rising edge
- opcode  in  3  command code (see Operation)
- input_data  in  N  signed operand for PUSH
- output_data  out  N  signed result register
- out_valid  out  1  one-cycle pulse: output_data updated this cycle
- overflow  out  1  last arithmetic op overflowed
- stack_error  out  1  last accepted op faulted (underflow or full)
- depth  out  $clog2(DEPTH+1)  current entry count

## Operation
- Operand naming: T = stack[depth-1] (top), S = stack[depth-2].
- State machine has two states:
  - IDLE: in_ready = 1.
  - MUL: in_ready = 0; commands are not accepted and are ignored.
- Opcodes:
  - 000 NOP: no change to any state or flag.
  - 001 SUB: result = S − T.
  - 100 ADD: result = S + T.
  - 101 MUL: result = S × T.
  - For SUB, ADD and MUL: needs depth ≥ 2. Pops two entries and pushes the result, so depth decreases by 1. output_data = result, out_valid pulses.
  - 010 DUP: needs 1 ≤ depth < DEPTH. Pushes a copy of T. No out_valid.
  - 011 SWAP: needs depth ≥ 2. Exchanges T and S. No out_valid.
  - 110 PUSH: needs depth < DEPTH. Pushes input_data. No out_valid.
  - 111 POP: needs depth ≥ 1. output_data = T, depth decreases by 1, out_valid pulses.
- Faults: if a requirement is unmet, set stack_error = 1. The stack, depth and output_data are unchanged, out_valid stays 0, overflow is cleared, and MUL state is not entered.
- Flags: every accepted non-NOP command rewrites stack_error. overflow is set only by ADD/SUB/MUL and cleared by every other non-NOP command. Both flags hold until rewritten.
- Overflow rules:
  - ADD/SUB: overflow when the exact (N+1)-bit result does not fit in N signed bits.
  - MUL: overflow when the exact 2N-bit product does not fit in N signed bits.
  - SATURATE=0: output the low N bits.
  - SATURATE=1: output 2^(N-1)−1 or −2^(N-1), chosen by the sign of the exact result.
- MUL datapath:
  - Operand magnitudes go through an N-iteration shift-add, one bit per cycle.
  - A 2N-bit accumulator holds the partial product.
  - Sign correction is applied at completion.
  - −2^(N-1) operands must be handled correctly.
- Stack storage is not cleared on pop or reset; contents above depth are don't-care.

## Timing
- Reset values (applied at the edge where reset = 1): depth 0, output_data 0, out_valid 0, overflow 0, stack_error 0, state IDLE, so in_ready = 1 after the edge. Reset overrides any command at that edge.
- Reset during MUL aborts it: no out_valid, and the stack is emptied (depth 0).
- Single-cycle ops: accepted at edge k. Stack, depth, flags, output_data and out_valid are all visible after edge k. out_valid is high for exactly that cycle.
- MUL: accepted at edge k, then in_ready = 0 after edges k … k+N−1.
  - At edge k+N: result written to the stack, depth decreases by 1, output_data/overflow updated, out_valid = 1, in_ready = 1.
  - Latency is N cycles; N = 32 gives 32.
  - Back-to-back single-cycle commands sustain one per cycle.
- in_ready is a function of state only, never of in_valid (no combinational loop).

## Test plan
- Reset; PUSH 5, PUSH 7, ADD → out_valid one cycle, output_data 12, depth 1, overflow 0, stack_error 0.
- PUSH 0x7FFFFFFF, PUSH 1, ADD:
  - SATURATE=0 → output_data 0x80000000, overflow 1.
  - SATURATE=1 → output_data 0x7FFFFFFF, overflow 1.
- PUSH −3, PUSH 4, MUL → in_ready low for 32 cycles, output_data −12 at edge k+32, depth 1.
- PUSH 0x10000 twice, MUL → overflow 1, output_data 0 (SATURATE=0).
- PUSH 10, PUSH 3, SUB → 7. Then PUSH 10, PUSH 3, SWAP, SUB → −7. Then DUP, POP → output_data −7, depth 2.
- 16 PUSHes, then a 17th PUSH → stack_error 1, depth stays 16. Reset, then POP on an empty stack → stack_error 1, out_valid 0, output_data 0.
- Start a MUL, assert reset 10 cycles later → depth 0, in_ready 1 after that edge, no out_valid pulse ever; toggling in_valid during MUL has no effect.
